// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared constants, command bundle type and helpers for the
//                two-requester pixel-memory arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    localparam int           REQ_NUM      = 2;
    localparam logic         ID_R0        = 1'b0;
    localparam logic         ID_R1        = 1'b1;
    localparam int           STAT_CNT_BIT = 16;

    // Memory geometry the command bundle is sized for; the arbiter's
    // ADDR_BIT/DATA_BIT parameters default to these and must track them.
    localparam int           MEM_ADDR_BIT = 10;
    localparam int           MEM_DATA_BIT = 32;

    typedef struct packed {
        logic                    we;
        logic [MEM_ADDR_BIT-1:0] addr;
        logic [MEM_DATA_BIT-1:0] wdata;
    } cmd_t;

    // Saturating increment for the grant statistics counters.
    function automatic logic [STAT_CNT_BIT-1:0] sat_inc(input logic [STAT_CNT_BIT-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_2req_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_2req_if
//  Description : Requester-side and memory-side signal bundle of the
//                two-requester arbiter. slave = arbiter view, master = the
//                surrounding clients and memory.
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_arb_2req_if #(
    parameter int ADDR_BIT = 10,
    parameter int DATA_BIT = 32
);
    logic                r0_req;
    logic                r0_we;
    logic [ADDR_BIT-1:0] r0_addr;
    logic [DATA_BIT-1:0] r0_wdata;
    logic                r0_gnt;
    logic                r0_rd_vld;
    logic [DATA_BIT-1:0] r0_rd_data;

    logic                r1_req;
    logic                r1_we;
    logic [ADDR_BIT-1:0] r1_addr;
    logic [DATA_BIT-1:0] r1_wdata;
    logic                r1_gnt;
    logic                r1_rd_vld;
    logic [DATA_BIT-1:0] r1_rd_data;

    logic                mem_wr_en;
    logic [ADDR_BIT-1:0] mem_wr_addr;
    logic [DATA_BIT-1:0] mem_wr_data;
    logic                mem_rd_en;
    logic [ADDR_BIT-1:0] mem_rd_addr;
    logic [DATA_BIT-1:0] mem_rd_data;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        output r0_gnt, r0_rd_vld, r0_rd_data,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        output r1_gnt, r1_rd_vld, r1_rd_data,
        output mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr,
        input  mem_rd_data
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        input  r0_gnt, r0_rd_vld, r0_rd_data,
        output r1_req, r1_we, r1_addr, r1_wdata,
        input  r1_gnt, r1_rd_vld, r1_rd_data,
        input  mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr,
        output mem_rd_data
    );
endinterface
`default_nettype wire

// File: rtl/mem_arb_2req_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Combinational two-way round-robin grant. A lone requester
//                wins; on contention the requester not granted most recently
//                wins.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arb2
    import mem_arb_pkg::*;
(
    input  wire logic [REQ_NUM-1:0] i_req,
    input  wire logic               i_last_gnt,
    output logic      [REQ_NUM-1:0] o_gnt,
    output logic                    o_last_gnt_nxt
);

    // One-hot grant plus the winner id to remember; holds when nobody asks.
    always_comb begin
        o_gnt          = '0;
        o_last_gnt_nxt = i_last_gnt;
        case (i_req)
            2'b01: begin
                o_gnt          = 2'b01;
                o_last_gnt_nxt = ID_R0;
            end
            2'b10: begin
                o_gnt          = 2'b10;
                o_last_gnt_nxt = ID_R1;
            end
            2'b11: begin
                if (i_last_gnt == ID_R1) begin
                    o_gnt          = 2'b01;
                    o_last_gnt_nxt = ID_R0;
                end else begin
                    o_gnt          = 2'b10;
                    o_last_gnt_nxt = ID_R1;
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_arb_2req.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_2req
//  Description : Round-robin arbiter sharing one registered-read single-port
//                memory between two requesters. Grants are combinational,
//                read data returns one cycle after the grant to the issuer.
//                Optional grant statistics: define MEM_ARB_STAT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arb_2req
    import mem_arb_pkg::*;
#(
    parameter int ADDR_BIT = MEM_ADDR_BIT,
    parameter int DATA_BIT = MEM_DATA_BIT
)(
    input  wire logic            clk,
    input  wire logic            rst,
    mem_arb_2req_if.slave        bus
`ifdef MEM_ARB_STAT_EN
    ,
    input  wire logic                    stat_clr,
    output logic      [STAT_CNT_BIT-1:0] r0_gnt_cnt,
    output logic      [STAT_CNT_BIT-1:0] r1_gnt_cnt
`endif
);

    logic [REQ_NUM-1:0] w_req;
    logic [REQ_NUM-1:0] w_gnt;
    logic               w_any_gnt;
    logic               w_win;
    cmd_t               w_cmd0;
    cmd_t               w_cmd1;
    cmd_t               w_sel;

    logic               w_last_gnt_d;
    logic               r_last_gnt_q;
    logic               w_rd_pend_d;
    logic               r_rd_pend_q;
    logic               w_rd_tag_d;
    logic               r_rd_tag_q;

    // Requests are masked during reset so nothing reaches the memory.
    assign w_req = rst ? '0 : {bus.r1_req, bus.r0_req};

    rr_arb2 u_rr_arb2 (
        .i_req          (w_req),
        .i_last_gnt     (r_last_gnt_q),
        .o_gnt          (w_gnt),
        .o_last_gnt_nxt (w_last_gnt_d)
    );

    assign w_any_gnt  = |w_gnt;
    assign w_win      = w_gnt[1] ? ID_R1 : ID_R0;
    assign bus.r0_gnt = w_gnt[0];
    assign bus.r1_gnt = w_gnt[1];

    assign w_cmd0 = '{we: bus.r0_we, addr: bus.r0_addr, wdata: bus.r0_wdata};
    assign w_cmd1 = '{we: bus.r1_we, addr: bus.r1_addr, wdata: bus.r1_wdata};
    assign w_sel  = (w_win == ID_R1) ? w_cmd1 : w_cmd0;

    // Drive the winner's command onto the memory pins; zeros when not strobed.
    always_comb begin
        bus.mem_wr_en   = 1'b0;
        bus.mem_wr_addr = '0;
        bus.mem_wr_data = '0;
        bus.mem_rd_en   = 1'b0;
        bus.mem_rd_addr = '0;
        if (w_any_gnt) begin
            if (w_sel.we) begin
                bus.mem_wr_en   = 1'b1;
                bus.mem_wr_addr = w_sel.addr;
                bus.mem_wr_data = w_sel.wdata;
            end else begin
                bus.mem_rd_en   = 1'b1;
                bus.mem_rd_addr = w_sel.addr;
            end
        end
    end

    // Remember whether a read was issued this cycle and by whom.
    always_comb begin
        w_rd_pend_d = w_any_gnt & ~w_sel.we;
        w_rd_tag_d  = w_any_gnt ? w_win : r_rd_tag_q;
    end

    // Arbitration history and read-return tag pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_gnt_q <= ID_R1;
            r_rd_pend_q  <= 1'b0;
            r_rd_tag_q   <= ID_R0;
        end else begin
            r_last_gnt_q <= w_last_gnt_d;
            r_rd_pend_q  <= w_rd_pend_d;
            r_rd_tag_q   <= w_rd_tag_d;
        end
    end

    // A read granted just before reset must not surface while reset is high.
    assign bus.r0_rd_vld  = ~rst & r_rd_pend_q & (r_rd_tag_q == ID_R0);
    assign bus.r1_rd_vld  = ~rst & r_rd_pend_q & (r_rd_tag_q == ID_R1);
    assign bus.r0_rd_data = bus.mem_rd_data;
    assign bus.r1_rd_data = bus.mem_rd_data;

`ifdef MEM_ARB_STAT_EN
    logic [STAT_CNT_BIT-1:0] w_r0_gnt_cnt_d;
    logic [STAT_CNT_BIT-1:0] r_r0_gnt_cnt_q;
    logic [STAT_CNT_BIT-1:0] w_r1_gnt_cnt_d;
    logic [STAT_CNT_BIT-1:0] r_r1_gnt_cnt_q;

    // Saturating grant counters; clear wins over increment.
    always_comb begin
        w_r0_gnt_cnt_d = r_r0_gnt_cnt_q;
        w_r1_gnt_cnt_d = r_r1_gnt_cnt_q;
        if (stat_clr) begin
            w_r0_gnt_cnt_d = '0;
            w_r1_gnt_cnt_d = '0;
        end else begin
            if (w_gnt[0]) w_r0_gnt_cnt_d = sat_inc(r_r0_gnt_cnt_q);
            if (w_gnt[1]) w_r1_gnt_cnt_d = sat_inc(r_r1_gnt_cnt_q);
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_r0_gnt_cnt_q <= '0;
            r_r1_gnt_cnt_q <= '0;
        end else begin
            r_r0_gnt_cnt_q <= w_r0_gnt_cnt_d;
            r_r1_gnt_cnt_q <= w_r1_gnt_cnt_d;
        end
    end

    assign r0_gnt_cnt = r_r0_gnt_cnt_q;
    assign r1_gnt_cnt = r_r1_gnt_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arb_2req.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arb_2req
//  Description : Self-checking bench for mem_arb_2req: directed scenarios and
//                a random run compared against a behavioural reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arb_2req;
    import mem_arb_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arb_2req_if #(.ADDR_BIT(AW), .DATA_BIT(DW)) bus();

`ifdef MEM_ARB_STAT_EN
    logic        stat_clr = 1'b0;
    logic [15:0] r0_gnt_cnt;
    logic [15:0] r1_gnt_cnt;
    int          cnt_m [2];
`endif

    mem_arb_2req #(.ADDR_BIT(AW), .DATA_BIT(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave)
`ifdef MEM_ARB_STAT_EN
        ,
        .stat_clr   (stat_clr),
        .r0_gnt_cnt (r0_gnt_cnt),
        .r1_gnt_cnt (r1_gnt_cnt)
`endif
    );

    // Memory instance the arbiter fronts: registered read, one access per cycle.
    logic [DW-1:0] mem_arr [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.mem_wr_en) mem_arr[bus.mem_wr_addr] <= bus.mem_wr_data;
        if (bus.mem_rd_en) bus.mem_rd_data <= mem_arr[bus.mem_rd_addr];
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            exp_last = 1;
    bit            exp_pend = 1'b0;
    int            exp_id   = 0;
    logic [DW-1:0] exp_data = '0;

    int n_chk = 0;
    int n_err = 0;
    int w;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive, check at the falling edge, advance the model.
    task automatic step(input logic rs,
                        input logic q0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic q1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        output int win);
        logic          we;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
        logic          acc;
        rst = rs;
        bus.r0_req = q0; bus.r0_we = w0; bus.r0_addr = a0; bus.r0_wdata = d0;
        bus.r1_req = q1; bus.r1_we = w1; bus.r1_addr = a1; bus.r1_wdata = d1;
        @(negedge clk);
        win = -1;
        if (!rs) begin
            if (q0 && q1)  win = (exp_last == 1) ? 0 : 1;
            else if (q0)   win = 0;
            else if (q1)   win = 1;
        end
        we  = (win == 1) ? w1 : w0;
        ad  = (win == 1) ? a1 : a0;
        wd  = (win == 1) ? d1 : d0;
        acc = (win >= 0);
        chk("r0_gnt",      bus.r0_gnt,      win == 0);
        chk("r1_gnt",      bus.r1_gnt,      win == 1);
        chk("mem_wr_en",   bus.mem_wr_en,   acc && we);
        chk("mem_rd_en",   bus.mem_rd_en,   acc && !we);
        chk("mem_wr_addr", bus.mem_wr_addr, (acc && we)  ? ad : '0);
        chk("mem_wr_data", bus.mem_wr_data, (acc && we)  ? wd : '0);
        chk("mem_rd_addr", bus.mem_rd_addr, (acc && !we) ? ad : '0);
        chk("r0_rd_vld",   bus.r0_rd_vld,   !rs && exp_pend && exp_id == 0);
        chk("r1_rd_vld",   bus.r1_rd_vld,   !rs && exp_pend && exp_id == 1);
        if (!rs && exp_pend && exp_id == 0) chk("r0_rd_data", bus.r0_rd_data, exp_data);
        if (!rs && exp_pend && exp_id == 1) chk("r1_rd_data", bus.r1_rd_data, exp_data);
`ifdef MEM_ARB_STAT_EN
        chk("r0_gnt_cnt", r0_gnt_cnt, cnt_m[0]);
        chk("r1_gnt_cnt", r1_gnt_cnt, cnt_m[1]);
        if (rs || stat_clr) begin
            cnt_m[0] = 0;
            cnt_m[1] = 0;
        end else if (acc && cnt_m[win] < 65535) begin
            cnt_m[win]++;
        end
`endif
        if (rs) begin
            exp_last = 1;
            exp_pend = 1'b0;
        end else begin
            exp_pend = acc && !we;
            if (acc) begin
                exp_last = win;
                exp_id   = win;
                if (we) ref_mem[ad] = wd;
                else    exp_data    = ref_mem[ad];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rs);
        int x;
        step(rs, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, x);
    endtask

    initial begin
        int na0, na1;
        logic p0, p1, rw0, rw1;
        logic [AW-1:0] ra0, ra1;
        logic [DW-1:0] rd0, rd1;
        int wt0, wt1;
        logic rs;

        for (int i = 0; i < (1 << AW); i++) begin
            mem_arr[i] = '0;
            ref_mem[i] = '0;
        end
        bus.mem_rd_data = '0;

        // Reset, including requests presented while reset is high.
        @(posedge clk); #1;
        idle(1'b1);
        step(1'b1, 1'b1, 1'b1, 10'd7, 32'h1234, 1'b1, 1'b0, 10'd7, '0, w);

        // r0 writes, then r1 reads the same address back.
        step(1'b0, 1'b1, 1'b1, 10'd5, 32'hA5A5_0001, 1'b0, 1'b0, '0, '0, w);
        chk("t_wr_win", w, 0);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'd5, '0, w);
        chk("t_rd_win", w, 1);
        idle(1'b0);

        // Preload 0..5 via r1, then contested reads alternate starting with r0.
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, AW'(i), DW'(i), w);
        na0 = 0;
        na1 = 1;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b1, 1'b0, AW'(na0), '0, 1'b1, 1'b0, AW'(na1), '0, w);
            chk("alt_gnt", w, k % 2);
            if (w == 0) na0 += 2;
            else        na1 += 2;
        end
        idle(1'b0);

        // r0 read immediately followed by reset: no read return, r0 wins first.
        step(1'b0, 1'b1, 1'b0, 10'd3, '0, 1'b0, 1'b0, '0, '0, w);
        idle(1'b1);
        step(1'b0, 1'b1, 1'b0, 10'd0, '0, 1'b1, 1'b0, 10'd1, '0, w);
        chk("post_rst_win", w, 0);
        idle(1'b0);

        // Random traffic; each requester holds its command until granted.
        p0 = 1'b0; p1 = 1'b0; wt0 = 0; wt1 = 0;
        rw0 = 1'b0; rw1 = 1'b0; ra0 = '0; ra1 = '0; rd0 = '0; rd1 = '0;
        for (int c = 0; c < 1000; c++) begin
            if (!p0 && $urandom_range(0, 2) != 0) begin
                p0 = 1'b1; rw0 = 1'($urandom_range(0, 1));
                ra0 = AW'($urandom_range(0, 15)); rd0 = $urandom;
            end
            if (!p1 && $urandom_range(0, 2) != 0) begin
                p1 = 1'b1; rw1 = 1'($urandom_range(0, 1));
                ra1 = AW'($urandom_range(0, 15)); rd1 = $urandom;
            end
            rs = ($urandom_range(0, 99) == 0);
            step(rs, p0, rw0, ra0, rd0, p1, rw1, ra1, rd1, w);
            chk("one_hot_gnt", bus.r0_gnt & bus.r1_gnt, 1'b0);
            chk("one_strobe",  bus.mem_wr_en & bus.mem_rd_en, 1'b0);
            if (rs) begin
                wt0 = 0;
                wt1 = 0;
            end else begin
                if (p0) wt0++;
                if (p1) wt1++;
            end
            if (w == 0) begin chk("r0_wait_le2", wt0 <= 2, 1'b1); p0 = 1'b0; wt0 = 0; end
            if (w == 1) begin chk("r1_wait_le2", wt1 <= 2, 1'b1); p1 = 1'b0; wt1 = 0; end
        end
        idle(1'b0);

`ifdef MEM_ARB_STAT_EN
        idle(1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, AW'(i), '0, 1'b0, 1'b0, '0, '0, w);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, AW'(i), DW'(i), w);
        chk("cnt0_3", r0_gnt_cnt, 16'd3);
        chk("cnt1_2", r1_gnt_cnt, 16'd2);
        stat_clr = 1'b1;
        step(1'b0, 1'b1, 1'b0, 10'd0, '0, 1'b0, 1'b0, '0, '0, w);
        stat_clr = 1'b0;
        chk("cnt0_clr", r0_gnt_cnt, 16'd0);
        chk("cnt1_clr", r1_gnt_cnt, 16'd0);
        force dut.r_r0_gnt_cnt_q = 16'hFFFF;
        #1;
        release dut.r_r0_gnt_cnt_q;
        cnt_m[0] = 65535;
        step(1'b0, 1'b1, 1'b0, 10'd0, '0, 1'b0, 1'b0, '0, '0, w);
        chk("cnt0_sat", r0_gnt_cnt, 16'hFFFF);
        idle(1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
